// File: rtl/uart_tx.sv
// UART serial transmitter: start bit, LSB-first data, optional parity, stop bit.
// One bit per clk cycle; tx_out and busy are registered from the next-state decode.
module uart_tx #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic                  tx_out,
    output logic                  busy
);

    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    par_en_q, par_en_d;
    logic                    par_typ_q, par_typ_d;
    logic                    tx_q, tx_d;
    logic                    busy_q, busy_d;

    // Next-state, latch and output computation
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        tx_d      = 1'b1;
        busy_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (data_valid) begin
                    data_d    = p_data;
                    par_en_d  = par_en;
                    par_typ_d = par_typ;
                    state_d   = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = DATA;
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = par_en_q ? PARITY : STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PARITY: begin
                state_d = STOP;
            end
            STOP: begin
                // A request landing on the stop cycle chains straight into the next start bit
                if (data_valid) begin
                    data_d    = p_data;
                    par_en_d  = par_en;
                    par_typ_d = par_typ;
                    state_d   = START;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs decoded from the upcoming state so the registered line tracks the FSM
        unique case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_d[cnt_d];
            PARITY:  tx_d = (^data_d) ^ par_typ_d;
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign tx_out = tx_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed frames plus randomized traffic
// checked against a queue-of-line-bits reference model.
module tb_uart_tx;

    logic       clk;
    logic       reset;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_en;
    logic       par_typ;
    logic       tx_out;
    logic       busy;

    int vectors;
    int miscompares;

    // Future line bits the reference model expects, one entry per cycle
    logic line_q[$];

    uart_tx #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .tx_out     (tx_out),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle: return what the line should show now, then drive the next inputs
    task automatic tick(input logic dv, input logic [7:0] d, input logic pe, input logic pt,
                        input logic rst, output logic etx, output logic ebusy);
        @(negedge clk);
        if (line_q.size() > 0) begin
            etx   = line_q.pop_front();
            ebusy = 1'b1;
        end else begin
            etx   = 1'b1;
            ebusy = 1'b0;
        end
        reset      = rst;
        data_valid = dv;
        p_data     = d;
        par_en     = pe;
        par_typ    = pt;
        if (rst) begin
            line_q.delete();
        end else if (dv && line_q.size() == 0) begin
            line_q.push_back(1'b0);
            for (int i = 0; i < 8; i++) line_q.push_back(d[i]);
            if (pe) line_q.push_back((^d) ^ pt);
            line_q.push_back(1'b1);
        end
    endtask

    task automatic test_reset();
        logic etx, eb;
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, etx, eb);
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, etx, eb);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), 1'b0, etx, eb);
            vectors++;
            if (tx_out !== 1'b1 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_idle cyc%0d: tx_out=%b busy=%b expected tx_out=1 busy=0", i, tx_out, busy);
            end
        end
        // Request coinciding with reset must be lost
        tick(1'b1, 8'h55, 1'b1, 1'b0, 1'b1, etx, eb);
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, etx, eb);
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, etx, eb);
        vectors++;
        if (tx_out !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_wins: tx_out=%b busy=%b expected tx_out=1 busy=0", tx_out, busy);
        end
    endtask

    task automatic test_parity_frame(input logic pt, input string name);
        logic etx, eb;
        logic exp_bits [11];
        logic [10:0] got;
        exp_bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_bits[9] = pt;
        tick(1'b1, 8'hA5, 1'b1, pt, 1'b0, etx, eb);
        for (int i = 0; i < 11; i++) begin
            tick(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), 1'b0, etx, eb);
            got[i] = tx_out;
            vectors++;
            if (tx_out !== exp_bits[i] || tx_out !== etx) begin
                miscompares++;
                $display("FAIL %s bit%0d: tx_out=%b expected %b", name, i, tx_out, exp_bits[i]);
            end
            vectors++;
            if (busy !== 1'b1) begin
                miscompares++;
                $display("FAIL %s busy%0d: busy=%b expected 1", name, i, busy);
            end
        end
        // Receiver-side parity check over data+parity bits
        vectors++;
        if (((^got[9:1]) ^ pt) !== 1'b0) begin
            miscompares++;
            $display("FAIL %s par_check: data+parity=%b parity type %b", name, got[9:1], pt);
        end
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, etx, eb);
        vectors++;
        if (busy !== 1'b0 || tx_out !== 1'b1) begin
            miscompares++;
            $display("FAIL %s end: busy=%b tx_out=%b expected busy=0 tx_out=1", name, busy, tx_out);
        end
    endtask

    task automatic test_no_parity();
        logic etx, eb;
        logic exp_bits [10];
        exp_bits = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tick(1'b1, 8'h01, 1'b0, 1'b1, 1'b0, etx, eb);
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, etx, eb);
            vectors++;
            if (tx_out !== exp_bits[i] || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL no_parity bit%0d: tx_out=%b busy=%b expected tx_out=%b busy=1", i, tx_out, busy, exp_bits[i]);
            end
        end
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, etx, eb);
        vectors++;
        if (busy !== 1'b0 || tx_out !== 1'b1) begin
            miscompares++;
            $display("FAIL no_parity end: busy=%b tx_out=%b expected busy=0 tx_out=1", busy, tx_out);
        end
    endtask

    task automatic test_back_to_back();
        logic etx, eb;
        logic exp2 [11];
        exp2 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tick(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, etx, eb);
        // Ticks 1..11 show the first frame; tick 3 is a DATA cycle, tick 11 the stop bit
        for (int t = 1; t <= 22; t++) begin
            if (t == 3 || t == 11)
                tick(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, etx, eb);
            else
                tick(1'b0, 8'h01, 1'b1, 1'b1, 1'b0, etx, eb);
            vectors++;
            if (tx_out !== etx || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b t%0d: tx_out=%b busy=%b expected tx_out=%b busy=1", t, tx_out, busy, etx);
            end
            if (t >= 12) begin
                vectors++;
                if (tx_out !== exp2[t-12]) begin
                    miscompares++;
                    $display("FAIL b2b frame2 bit%0d: tx_out=%b expected %b", t - 12, tx_out, exp2[t-12]);
                end
            end
        end
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, etx, eb);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b end: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic etx, eb;
        tick(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, etx, eb);
        for (int t = 1; t <= 5; t++) tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, etx, eb);
        // Tick 6 shows data bit 4; assert reset there
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, etx, eb);
        vectors++;
        if (tx_out !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset bit4: tx_out=%b busy=%b expected tx_out=0 busy=1", tx_out, busy);
        end
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, etx, eb);
        vectors++;
        if (tx_out !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset abort: tx_out=%b busy=%b expected tx_out=1 busy=0", tx_out, busy);
        end
        tick(1'b1, 8'h96, 1'b1, 1'b1, 1'b0, etx, eb);
        for (int t = 0; t < 12; t++) begin
            tick(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), 1'b0, etx, eb);
            vectors++;
            if (tx_out !== etx || busy !== eb) begin
                miscompares++;
                $display("FAIL mid_reset refr t%0d: tx_out=%b busy=%b expected tx_out=%b busy=%b", t, tx_out, busy, etx, eb);
            end
        end
    endtask

    task automatic test_random();
        logic etx, eb;
        for (int t = 0; t < 600; t++) begin
            tick(($urandom_range(0, 3) == 0), 8'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 79) == 0), etx, eb);
            vectors++;
            if (tx_out !== etx || busy !== eb) begin
                miscompares++;
                $display("FAIL random t%0d: tx_out=%b busy=%b expected tx_out=%b busy=%b", t, tx_out, busy, etx, eb);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        data_valid  = 1'b0;
        p_data      = 8'h00;
        par_en      = 1'b0;
        par_typ     = 1'b0;
        test_reset();
        test_parity_frame(1'b0, "even_a5");
        test_parity_frame(1'b1, "odd_a5");
        test_no_parity();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
